regf_wb_arb: RTL and testbench
==============================

REGF_WB_ARB -- requirements
Module: regf_wb_arb

Interface
REQ-001 SHALL have ports: i_clk  in  1  system clock, rising edge.
REQ-002 SHALL have ports: i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: i_exu_valid, i_lsu_valid  in  1  requester write request.
REQ-004 SHALL have ports: o_exu_ready, o_lsu_ready  out  1  requester slot can accept.
REQ-005 SHALL have ports: i_exu_waddr, i_lsu_waddr  in  `CPU_ADDR  destination register.
REQ-006 SHALL have ports: i_exu_wdata, i_lsu_wdata  in  `CPU_WIDTH  write data.
REQ-007 SHALL have ports: o_regf_en  out  1, o_regf_waddr  out  `CPU_ADDR, o_regf_wdata  out  `CPU_WIDTH; these drive the register-file write port.
REQ-008 SHALL have port: o_idle  out  1  both slots empty.
REQ-009 Port list SHALL NOT include parameters; widths SHALL come from `CPU_ADDR / `CPU_WIDTH only.

Function
REQ-010 Each requester SHALL own a one-entry slot: full bit, waddr, wdata.
REQ-011 A transfer SHALL occur when valid and ready are both high at a rising edge; the slot SHALL be loaded at that edge.
REQ-012 ready SHALL equal (slot empty) OR (slot granted this cycle), so a requester sustains one write per cycle when uncontended.
REQ-013 A transfer with waddr == 0 SHALL be accepted and discarded: the slot is not loaded and no write is issued.
REQ-014 Grant rules: at most one slot granted per cycle. A lone full slot SHALL be granted. Two full slots SHALL be arbitrated round-robin, except as REQ-015 requires.
REQ-015 If both slots are full with equal waddr, the older slot SHALL be granted first.
- Age bit SHALL be set when a slot loads while the other is already full and not draining.
- Same-edge loads SHALL treat EXU as older.
REQ-016 Round-robin pointer SHALL move to the non-granted requester after each contended grant; uncontended grants SHALL leave it unchanged.
REQ-017 o_regf_en SHALL be high iff a slot is granted. o_regf_waddr/o_regf_wdata SHALL equal the granted slot's fields; they SHALL be 0 when o_regf_en is low.
REQ-018 The granted slot SHALL clear at the same edge the register file writes, unless it is reloaded at that edge.
REQ-019 Latency: a transfer at edge N SHALL give o_regf_en high in cycle N..N+1 at the earliest, and the write at edge N+1.
REQ-020 Worst-case wait: a full slot under continuous contention SHALL be granted within 2 cycles.
REQ-021 o_idle SHALL be high iff both slots are empty; it SHALL be a function of registered state only.
REQ-022 No output SHALL depend combinationally on i_*_valid; ready SHALL depend only on slot state and grant.

Reset
REQ-023 On i_rst_n low, SHALL asynchronously clear both full bits, the age bit and the data fields; the round-robin pointer SHALL reset to EXU.
REQ-024 During reset, SHALL drive o_exu_ready = o_lsu_ready = 1, o_regf_en = 0, o_regf_waddr = 0, o_regf_wdata = 0, o_idle = 1.
REQ-025 Reset mid-operation SHALL discard pending writes; no partial write SHALL be issued.

Configuration
REQ-026 Macro REGF_WB_BYPASS_EN, when defined, SHALL add forwarding ports:
- i_rs1_addr, i_rs2_addr  in  `CPU_ADDR.
- o_rs1_hit, o_rs2_hit  out  1.
- o_rs1_data, o_rs2_data  out  `CPU_WIDTH.
REQ-027 With the macro defined, hit SHALL be set when any full slot matches a nonzero rs address, and data SHALL come from the younger matching slot (age bit). With no match, hit = 0 and data = 0.
REQ-028 With the macro undefined, the forwarding ports and logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 The slot width and requester-index constants (REQ_EXU=0, REQ_LSU=1) SHALL live in the shared defines header beside `CPU_ADDR / `CPU_WIDTH / `REG_NUM.
REQ-030 The slot SHALL be one sub-module, regf_wb_slot, holding the full bit, waddr and wdata; it SHALL be instantiated once per requester.
REQ-031 Arbitration, age and pointer logic SHALL stay in regf_wb_arb.

Verification
REQ-032 Single write: EXU sends x5=0x1234 while LSU is idle. Required response: o_regf_en=1, waddr=5, wdata=0x1234 in the next cycle; o_idle then returns to 1.
REQ-033 Contention: both requesters hold valid for 4 cycles, to x1 and x2. Required response: grants alternate EXU, LSU, EXU, LSU after reset, and no write is lost.
REQ-034 Same address: LSU loads x7=0xA, then EXU loads x7=0xB one cycle later while LSU is stalled full. Required response: 0xA is written before 0xB.
REQ-035 x0 discard: EXU sends x0=0xFFFF_FFFF. Required response: ready=1, o_regf_en stays 0, o_idle stays 1.
REQ-036 Mid-operation reset: i_rst_n is pulled low with both slots full. Required response: outputs take reset values immediately, and no write is issued after release.
REQ-037 Bypass (macro defined): slot holds x3=0x55 and i_rs1_addr=3. Required response: o_rs1_hit=1, o_rs1_data=0x55. With i_rs1_addr=0, o_rs1_hit=0.

Source files
------------

// File: rtl/regf_wb_pkg.sv
// ============================================================================
// Module : regf_wb_pkg
// Desc   : Shared widths, requester indices and slot helpers for regf_wb_arb.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef REGF_WB_DEFINES
`define REGF_WB_DEFINES
`define CPU_ADDR   5
`define CPU_WIDTH  32
`define REG_NUM    32
`define REQ_EXU    0
`define REQ_LSU    1
`define SLOT_W     (1 + `CPU_ADDR + `CPU_WIDTH)
`endif

package regf_wb_pkg;

    localparam int unsigned REQ_EXU = `REQ_EXU;
    localparam int unsigned REQ_LSU = `REQ_LSU;
    localparam int unsigned SLOT_W  = `SLOT_W;

    // Forwarding picks the younger slot when both match the same register.
    function automatic logic [`CPU_WIDTH-1:0] fwd_data(
        input logic                  hit_exu,
        input logic                  hit_lsu,
        input logic                  lsu_older,
        input logic [`CPU_WIDTH-1:0] exu_data,
        input logic [`CPU_WIDTH-1:0] lsu_data
    );
        logic [`CPU_WIDTH-1:0] data;
        data = '0;
        if (hit_exu && hit_lsu) data = lsu_older ? exu_data : lsu_data;
        else if (hit_exu)       data = exu_data;
        else if (hit_lsu)       data = lsu_data;
        return data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regf_wb_slot.sv
// ============================================================================
// Module : regf_wb_slot
// Desc   : One-entry write-back holding slot (full bit, waddr, wdata).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regf_wb_slot
    import regf_wb_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [`CPU_ADDR-1:0]  i_waddr,
    input  logic [`CPU_WIDTH-1:0] i_wdata,
    output logic                  o_full,
    output logic [`CPU_ADDR-1:0]  o_waddr,
    output logic [`CPU_WIDTH-1:0] o_wdata
);

    logic                  full_q,  full_d;
    logic [`CPU_ADDR-1:0]  waddr_q, waddr_d;
    logic [`CPU_WIDTH-1:0] wdata_q, wdata_d;

    // A reload on the draining edge wins over the clear.
    always_comb begin
        full_d  = full_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (i_load) begin
            full_d  = 1'b1;
            waddr_d = i_waddr;
            wdata_d = i_wdata;
        end else if (i_clear) begin
            full_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            full_q  <= full_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_full  = full_q;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;

endmodule

`default_nettype wire

// File: rtl/regf_wb_arb.sv
// ============================================================================
// Module : regf_wb_arb
// Desc   : EXU/LSU register-file write-back arbiter with per-requester slots.
//          Optional forwarding ports enabled by macro REGF_WB_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regf_wb_arb
    import regf_wb_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_exu_valid,
    input  logic                  i_lsu_valid,
    output logic                  o_exu_ready,
    output logic                  o_lsu_ready,
    input  logic [`CPU_ADDR-1:0]  i_exu_waddr,
    input  logic [`CPU_ADDR-1:0]  i_lsu_waddr,
    input  logic [`CPU_WIDTH-1:0] i_exu_wdata,
    input  logic [`CPU_WIDTH-1:0] i_lsu_wdata,
    output logic                  o_regf_en,
    output logic [`CPU_ADDR-1:0]  o_regf_waddr,
    output logic [`CPU_WIDTH-1:0] o_regf_wdata,
`ifdef REGF_WB_BYPASS_EN
    input  logic [`CPU_ADDR-1:0]  i_rs1_addr,
    input  logic [`CPU_ADDR-1:0]  i_rs2_addr,
    output logic                  o_rs1_hit,
    output logic                  o_rs2_hit,
    output logic [`CPU_WIDTH-1:0] o_rs1_data,
    output logic [`CPU_WIDTH-1:0] o_rs2_data,
`endif
    output logic                  o_idle
);

    logic                  w_exu_full,  w_lsu_full;
    logic [`CPU_ADDR-1:0]  w_exu_waddr, w_lsu_waddr;
    logic [`CPU_WIDTH-1:0] w_exu_wdata, w_lsu_wdata;
    logic                  w_both, w_pick_lsu, w_gnt_exu, w_gnt_lsu;
    logic                  w_exu_ready, w_lsu_ready, w_exu_load, w_lsu_load;

    // age_q = 1 means the LSU slot is the older one; rr_q = 1 means LSU's turn.
    logic age_q, age_d;
    logic rr_q,  rr_d;

    regf_wb_slot u_slot_exu (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_exu_load),
        .i_clear (w_gnt_exu),
        .i_waddr (i_exu_waddr),
        .i_wdata (i_exu_wdata),
        .o_full  (w_exu_full),
        .o_waddr (w_exu_waddr),
        .o_wdata (w_exu_wdata)
    );

    regf_wb_slot u_slot_lsu (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_lsu_load),
        .i_clear (w_gnt_lsu),
        .i_waddr (i_lsu_waddr),
        .i_wdata (i_lsu_wdata),
        .o_full  (w_lsu_full),
        .o_waddr (w_lsu_waddr),
        .o_wdata (w_lsu_wdata)
    );

    assign w_both     = w_exu_full & w_lsu_full;
    assign w_pick_lsu = w_both & ((w_exu_waddr == w_lsu_waddr) ? age_q : rr_q);
    assign w_gnt_exu  = w_exu_full & ~w_pick_lsu;
    assign w_gnt_lsu  = w_lsu_full & ~w_gnt_exu;

    assign w_exu_ready = ~w_exu_full | w_gnt_exu;
    assign w_lsu_ready = ~w_lsu_full | w_gnt_lsu;

    // Writes to x0 complete the handshake but never occupy a slot.
    assign w_exu_load = i_exu_valid & w_exu_ready & (i_exu_waddr != '0);
    assign w_lsu_load = i_lsu_valid & w_lsu_ready & (i_lsu_waddr != '0);

    always_comb begin
        age_d = age_q;
        if (w_exu_load && w_lsu_load)
            age_d = 1'b0;
        else if (w_exu_load && w_lsu_full && !w_gnt_lsu)
            age_d = 1'b1;
        else if (w_lsu_load && w_exu_full && !w_gnt_exu)
            age_d = 1'b0;
    end

    always_comb begin
        rr_d = rr_q;
        if (w_both) rr_d = w_gnt_exu;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            age_q <= 1'b0;
            rr_q  <= 1'b0;
        end else begin
            age_q <= age_d;
            rr_q  <= rr_d;
        end
    end

    assign o_exu_ready  = w_exu_ready;
    assign o_lsu_ready  = w_lsu_ready;
    assign o_regf_en    = w_gnt_exu | w_gnt_lsu;
    assign o_regf_waddr = w_gnt_exu ? w_exu_waddr : (w_gnt_lsu ? w_lsu_waddr : '0);
    assign o_regf_wdata = w_gnt_exu ? w_exu_wdata : (w_gnt_lsu ? w_lsu_wdata : '0);
    assign o_idle       = ~w_exu_full & ~w_lsu_full;

`ifdef REGF_WB_BYPASS_EN
    logic w_rs1_exu, w_rs1_lsu, w_rs2_exu, w_rs2_lsu;

    assign w_rs1_exu = w_exu_full & (i_rs1_addr != '0) & (w_exu_waddr == i_rs1_addr);
    assign w_rs1_lsu = w_lsu_full & (i_rs1_addr != '0) & (w_lsu_waddr == i_rs1_addr);
    assign w_rs2_exu = w_exu_full & (i_rs2_addr != '0) & (w_exu_waddr == i_rs2_addr);
    assign w_rs2_lsu = w_lsu_full & (i_rs2_addr != '0) & (w_lsu_waddr == i_rs2_addr);

    assign o_rs1_hit  = w_rs1_exu | w_rs1_lsu;
    assign o_rs2_hit  = w_rs2_exu | w_rs2_lsu;
    assign o_rs1_data = fwd_data(w_rs1_exu, w_rs1_lsu, age_q, w_exu_wdata, w_lsu_wdata);
    assign o_rs2_data = fwd_data(w_rs2_exu, w_rs2_lsu, age_q, w_exu_wdata, w_lsu_wdata);
`endif

endmodule

`default_nettype wire

// File: tb/tb_regf_wb_arb.sv
// ============================================================================
// Module : tb_regf_wb_arb
// Desc   : Directed self-checking bench for regf_wb_arb (REGF_WB_BYPASS_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regf_wb_arb;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  ev, lv, er, lr, en, idle;
    logic [`CPU_ADDR-1:0]  ea, la, wa;
    logic [`CPU_WIDTH-1:0] ed, ld, wd;
`ifdef REGF_WB_BYPASS_EN
    logic [`CPU_ADDR-1:0]  rs1, rs2;
    logic                  h1, h2;
    logic [`CPU_WIDTH-1:0] d1, d2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regf_wb_arb dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_exu_valid  (ev),
        .i_lsu_valid  (lv),
        .o_exu_ready  (er),
        .o_lsu_ready  (lr),
        .i_exu_waddr  (ea),
        .i_lsu_waddr  (la),
        .i_exu_wdata  (ed),
        .i_lsu_wdata  (ld),
        .o_regf_en    (en),
        .o_regf_waddr (wa),
        .o_regf_wdata (wd),
`ifdef REGF_WB_BYPASS_EN
        .i_rs1_addr   (rs1),
        .i_rs2_addr   (rs2),
        .o_rs1_hit    (h1),
        .o_rs2_hit    (h2),
        .o_rs1_data   (d1),
        .o_rs2_data   (d2),
`endif
        .o_idle       (idle)
    );

    task step;
        @(posedge clk);
        #1;
    endtask

    task drive(input logic v_e, input logic [4:0] a_e, input logic [31:0] d_e,
               input logic v_l, input logic [4:0] a_l, input logic [31:0] d_l);
        ev = v_e; ea = a_e; ed = d_e;
        lv = v_l; la = a_l; ld = d_l;
    endtask

    task test_reset;
        rst_n = 1'b0;
        drive(1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd6, 32'hBEEF);
        #3;
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL rst_exu_ready got %b exp 1", er); end
        checks++; if (lr !== 1'b1) begin errors++; $display("FAIL rst_lsu_ready got %b exp 1", lr); end
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", en); end
        checks++; if (wa !== 5'd0) begin errors++; $display("FAIL rst_waddr got %0h exp 0", wa); end
        checks++; if (wd !== 32'd0) begin errors++; $display("FAIL rst_wdata got %0h exp 0", wd); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", idle); end
        step;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_no_load got idle %b exp 1", idle); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2 rst_n = 1'b1;
        step;
    endtask

    // Both requesters hold valid for 4 cycles to x1 / x2; grants alternate.
    task test_contention;
        logic        t_ev [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_ed [7] = '{32'h100, 32'h101, 32'h101, 32'h102, 32'h102, 32'h102, 32'h102};
        logic [31:0] t_ld [7] = '{32'h200, 32'h200, 32'h201, 32'h201, 32'h201, 32'h201, 32'h201};
        logic        x_en [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0]  x_wa [7] = '{5'd0, 5'd1, 5'd2, 5'd1, 5'd2, 5'd1, 5'd0};
        logic [31:0] x_wd [7] = '{32'h0, 32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h0};
        logic        x_er [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        x_lr [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            drive(t_ev[k], 5'd1, t_ed[k], t_ev[k], 5'd2, t_ld[k]);
            checks++; if (en !== x_en[k]) begin errors++; $display("FAIL cont_en[%0d] got %b exp %b", k, en, x_en[k]); end
            checks++; if (wa !== x_wa[k]) begin errors++; $display("FAIL cont_waddr[%0d] got %0h exp %0h", k, wa, x_wa[k]); end
            checks++; if (wd !== x_wd[k]) begin errors++; $display("FAIL cont_wdata[%0d] got %0h exp %0h", k, wd, x_wd[k]); end
            checks++; if (er !== x_er[k]) begin errors++; $display("FAIL cont_exu_ready[%0d] got %b exp %b", k, er, x_er[k]); end
            checks++; if (lr !== x_lr[k]) begin errors++; $display("FAIL cont_lsu_ready[%0d] got %b exp %b", k, lr, x_lr[k]); end
            step;
        end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL cont_idle got %b exp 1", idle); end
    endtask

    task test_single;
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", er); end
        step;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL single_en got %b exp 1", en); end
        checks++; if (wa !== 5'd5) begin errors++; $display("FAIL single_waddr got %0h exp 5", wa); end
        checks++; if (wd !== 32'h1234) begin errors++; $display("FAIL single_wdata got %0h exp 1234", wd); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", idle); end
        step;
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL single_en_off got %b exp 0", en); end
        checks++; if (wd !== 32'd0) begin errors++; $display("FAIL single_wdata_off got %0h exp 0", wd); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got %b exp 1", idle); end
    endtask

    task test_x0_discard;
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", er); end
        step;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL x0_en got %b exp 0", en); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL x0_idle got %b exp 1", idle); end
    endtask

    // LSU writes x7=0xA, EXU writes x7=0xB one cycle later: 0xA must land first.
    task test_same_addr;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA);
        step;
        drive(1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 32'd0);
        checks++; if ({en, wa, wd} !== {1'b1, 5'd7, 32'hA}) begin errors++; $display("FAIL same_first got %b/%0h/%0h exp 1/7/a", en, wa, wd); end
        step;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++; if ({en, wa, wd} !== {1'b1, 5'd7, 32'hB}) begin errors++; $display("FAIL same_second got %b/%0h/%0h exp 1/7/b", en, wa, wd); end
        step;
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL same_done got %b exp 0", en); end
    endtask

    // Pointer left on LSU, then same-edge loads to x6: EXU is older and wins.
    task test_age_over_rr;
        logic        t_ev [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [4:0]  t_ea [6] = '{5'd1, 5'd0, 5'd6, 5'd0, 5'd0, 5'd0};
        logic [31:0] t_ed [6] = '{32'h11, 32'h0, 32'hE, 32'h0, 32'h0, 32'h0};
        logic [4:0]  t_la [6] = '{5'd2, 5'd0, 5'd6, 5'd0, 5'd0, 5'd0};
        logic [31:0] t_ld [6] = '{32'h22, 32'h0, 32'hF, 32'h0, 32'h0, 32'h0};
        logic        x_en [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0]  x_wa [6] = '{5'd0, 5'd1, 5'd2, 5'd6, 5'd6, 5'd0};
        logic [31:0] x_wd [6] = '{32'h0, 32'h11, 32'h22, 32'hE, 32'hF, 32'h0};
        for (int k = 0; k < 6; k++) begin
            drive(t_ev[k], t_ea[k], t_ed[k], t_ev[k], t_la[k], t_ld[k]);
            checks++; if ({en, wa, wd} !== {x_en[k], x_wa[k], x_wd[k]}) begin
                errors++;
                $display("FAIL age_write[%0d] got %b/%0h/%0h exp %b/%0h/%0h", k, en, wa, wd, x_en[k], x_wa[k], x_wd[k]);
            end
            step;
        end
    endtask

    task test_mid_reset;
        drive(1'b1, 5'd10, 32'h1, 1'b1, 5'd11, 32'h2);
        step;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL mrst_loaded got idle %b exp 0", idle); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL mrst_en got %b exp 0", en); end
        checks++; if (wa !== 5'd0) begin errors++; $display("FAIL mrst_waddr got %0h exp 0", wa); end
        checks++; if (wd !== 32'd0) begin errors++; $display("FAIL mrst_wdata got %0h exp 0", wd); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mrst_idle got %b exp 1", idle); end
        checks++; if ({er, lr} !== 2'b11) begin errors++; $display("FAIL mrst_ready got %b exp 11", {er, lr}); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        step;
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL mrst_after_en got %b exp 0", en); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mrst_after_idle got %b exp 1", idle); end
        step;
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL mrst_after_en2 got %b exp 0", en); end
    endtask

`ifdef REGF_WB_BYPASS_EN
    task test_bypass;
        rs1 = 5'd3; rs2 = 5'd0;
        drive(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'd0);
        step;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++; if (h1 !== 1'b1) begin errors++; $display("FAIL byp_hit got %b exp 1", h1); end
        checks++; if (d1 !== 32'h55) begin errors++; $display("FAIL byp_data got %0h exp 55", d1); end
        checks++; if ({h2, d2} !== 33'd0) begin errors++; $display("FAIL byp_rs2 got %b/%0h exp 0/0", h2, d2); end
        rs1 = 5'd0;
        #1;
        checks++; if (h1 !== 1'b0) begin errors++; $display("FAIL byp_x0_hit got %b exp 0", h1); end
        step;
    endtask
`endif

    initial begin
`ifdef REGF_WB_BYPASS_EN
        rs1 = 5'd0;
        rs2 = 5'd0;
`endif
        test_reset;
        test_contention;
        test_single;
        test_x0_discard;
        test_same_addr;
        test_age_over_rr;
        test_mid_reset;
`ifdef REGF_WB_BYPASS_EN
        test_bypass;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
